// File: rtl/audio_pkg.sv
// Shared types and constants for the sound arbiter.
// Source indices grow with priority.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } arb_state_t;

  localparam int SRC_JUMP  = 0;
  localparam int SRC_SCORE = 1;
  localparam int SRC_WIN   = 2;
  localparam int SRC_LOSE  = 3;

  localparam int DEFAULT_PLAY_CYCLES = 12500000;
  localparam int DEFAULT_GAP_CYCLES  = 1250000;

endpackage

// File: rtl/prio_pick.sv
// Highest-set-bit encoder.
// Returns the top set index and a valid flag.
module prio_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = |vec;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/sound_arbiter.sv
// Fixed-priority arbiter sharing one speaker
// among several square-wave sound generators.
module sound_arbiter
  import audio_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int TIMER_W     = 24,
  parameter int PLAY_CYCLES = DEFAULT_PLAY_CYCLES,
  parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
  localparam int IW         = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  input  logic             clear,
  input  logic [N_SRC-1:0] sound_in,
  output logic [N_SRC-1:0] enable,
  output logic [IW-1:0]    active_idx,
  output logic             busy_play,
  output logic [N_SRC-1:0] pending,
  output logic             sound
);

  localparam int PLAY_M1 = PLAY_CYCLES - 1;
  localparam int GAP_M1  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [TIMER_W-1:0] PLAY_LOAD = PLAY_M1[TIMER_W-1:0];
  localparam logic [TIMER_W-1:0] GAP_LOAD  = GAP_M1[TIMER_W-1:0];

  if (PLAY_CYCLES < 1 ||
      longint'(PLAY_CYCLES) >= (longint'(1) << TIMER_W)) begin : g_bad_play
    $error("PLAY_CYCLES must be in [1, 2^TIMER_W)");
  end
  if (GAP_CYCLES < 0 ||
      longint'(GAP_CYCLES) > (longint'(1) << TIMER_W)) begin : g_bad_gap
    $error("GAP_CYCLES out of range for TIMER_W");
  end

  arb_state_t         state, state_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [N_SRC-1:0]   pend_n;
  logic [IW-1:0]      idx_n;
  logic [N_SRC-1:0]   req_prev;
  logic [N_SRC-1:0]   edges;
  logic               ev, pv, do_sel;
  logic [IW-1:0]      eidx, pidx;
  logic [N_SRC-1:0]   e_oh, p_oh, a_oh;

  assign edges = req & ~req_prev;

  prio_pick #(.N(N_SRC), .W(IW)) u_pick_edge (
    .vec   (edges),
    .valid (ev),
    .idx   (eidx)
  );

  prio_pick #(.N(N_SRC), .W(IW)) u_pick_pend (
    .vec   (pending),
    .valid (pv),
    .idx   (pidx)
  );

  assign e_oh = N_SRC'(1) << eidx;
  assign p_oh = N_SRC'(1) << pidx;
  assign a_oh = N_SRC'(1) << active_idx;

  always_comb begin
    state_n = state;
    timer_n = timer;
    pend_n  = pending;
    idx_n   = active_idx;
    do_sel  = 1'b0;
    unique case (state)
      IDLE: do_sel = 1'b1;
      PLAY: begin
        if (ev && eidx > active_idx) begin
          // preempted sound is dropped, not re-queued
          idx_n   = eidx;
          timer_n = PLAY_LOAD;
          pend_n  = pending | (edges & ~e_oh & ~a_oh);
        end else if (ev && eidx == active_idx) begin
          timer_n = PLAY_LOAD;
          pend_n  = pending | (edges & ~a_oh);
        end else if (timer == '0) begin
          if (GAP_CYCLES == 0) begin
            do_sel = 1'b1;
          end else begin
            state_n = GAP;
            timer_n = GAP_LOAD;
            pend_n  = pending | edges;
          end
        end else begin
          timer_n = timer - 1'b1;
          pend_n  = pending | edges;
        end
      end
      GAP: begin
        if (timer == '0) begin
          do_sel = 1'b1;
        end else begin
          timer_n = timer - 1'b1;
          pend_n  = pending | edges;
        end
      end
      default: state_n = IDLE;
    endcase

    if (do_sel) begin
      if (ev) begin
        state_n = PLAY;
        idx_n   = eidx;
        timer_n = PLAY_LOAD;
        pend_n  = pending | (edges & ~e_oh);
      end else if (pv) begin
        state_n = PLAY;
        idx_n   = pidx;
        timer_n = PLAY_LOAD;
        pend_n  = pending & ~p_oh;
      end else begin
        state_n = IDLE;
        timer_n = '0;
      end
    end

    if (clear) begin
      state_n = IDLE;
      timer_n = '0;
      pend_n  = '0;
      idx_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      pending    <= '0;
      active_idx <= '0;
      req_prev   <= '1;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      pending    <= pend_n;
      active_idx <= idx_n;
      req_prev   <= req;
    end
  end

  assign busy_play = (state == PLAY);
  assign enable    = busy_play ? a_oh : '0;
  assign sound     = busy_play & sound_in[active_idx];

endmodule

// File: doc/sound_arbiter.md
Name: sound_arbiter

Overview:
- Shares the single speaker output among N_SRC sound generators (jump, score, win, lose, ...).
- Rising edges on per-source request lines are arbitrated by fixed priority; a higher-priority request preempts, and a lower or equal one is queued in a pending mask.
- Drives a one-hot enable to the selected generator and muxes that generator's square wave to `sound`.
- Sits between game-logic event outputs and the audio generator instances, replacing ad-hoc single-slot latching.

Parameters:
- N_SRC, 4, number of requesting sound sources. Index N_SRC-1 has the highest priority.
- TIMER_W, 24, width of the play/gap counters.
- PLAY_CYCLES, 12500000, cycles each sound plays. Must be ≥1.
- GAP_CYCLES, 1250000, silent cycles between queued sounds. 0 means back-to-back.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_SRC  level request per source; only the rising edge counts
- clear  in  1  synchronous flush: stop playback and drop all pending requests
- sound_in  in  N_SRC  square-wave output of each generator
- enable  out  N_SRC  one-hot enable to the selected generator
- active_idx  out  $clog2(N_SRC)  index of the sound being played; valid only while busy_play=1
- busy_play  out  1  high while in PLAY
- pending  out  N_SRC  queued-request mask
- sound  out  1  sound_in[active_idx] when in PLAY, else 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; enable, pending, active_idx, busy_play and sound are all 0.
  - req_prev resets to all ones, so a level already held high across reset does not trigger.
- Edge detect: edge[i] = req[i] & ~req_prev[i]; req_prev is registered every cycle, including while clear=1.
- States:
  - IDLE: if any edge, the highest edge index enters PLAY on the next clock; other same-cycle edges set their pending bits. Otherwise, if pending≠0, start the highest pending index and clear its bit.
  - PLAY: timer is loaded with PLAY_CYCLES-1 on entry and decrements each cycle.
    - Edge with index > active: preempt. The new index enters PLAY next cycle, timer reloads, and the preempted sound is dropped (not re-queued).
    - Edge with index == active: restart the timer. No pending bit is set.
    - Edge with index < active: set pending[index].
    - Multiple edges in one cycle: the highest one is handled per the rules above; all others set pending (excluding active).
    - timer==0 with no preempt: go to GAP (timer=GAP_CYCLES-1). If GAP_CYCLES=0, apply the IDLE selection rule in the same cycle.
  - GAP: enable=0, sound=0.
    - Edges only set pending bits; the gap is never shortened.
    - At timer==0, apply the IDLE selection rule.
- Latency:
  - The first clock sampling req[i]=1 (with req_prev[i]=0) registers the decision.
  - enable, busy_play and active_idx are valid on the following clock edge (1 cycle).
  - sound is combinational from sound_in once enable is valid.
- PLAY lasts exactly PLAY_CYCLES cycles with enable high, unless preempted or cleared.
- clear=1 has priority over every rule: next state is IDLE, pending=0, edges in that cycle are discarded.
- Timer arithmetic: unsigned TIMER_W bits; it never decrements below 0. PLAY_CYCLES must be < 2^TIMER_W (elaboration assertion).
- pending bit i is set and cleared only by the rules above. Setting an already-set bit is a no-op (at most one queued instance per source).
- enable is always one-hot or zero. It is never asserted outside PLAY.

Decomposition:
- Package audio_pkg:
  - arb_state_t enum {IDLE, PLAY, GAP}.
  - Source index constants SRC_JUMP=0, SRC_SCORE=1, SRC_WIN=2, SRC_LOSE=3 (lose outranks win).
  - Default PLAY_CYCLES/GAP_CYCLES localparams.
- Sub-module prio_pick: parameterised highest-set-bit encoder returning {valid, idx}. It is instantiated twice, once for edges and once for pending.

Test Plan (N_SRC=4, PLAY_CYCLES=8, GAP_CYCLES=2):
1. Reset behaviour: hold req=4'b0001 through reset release -> no playback. Drop req, then raise req[0] -> enable=0001 one cycle later for exactly 8 cycles, then 2 silent cycles, then IDLE; sound tracks sound_in[0] only during those 8 cycles.
2. Queueing: req[2] edge, then req[0] edge at play cycle 3 -> pending=0001. Win plays 8 cycles, gap of 2 cycles, then enable=0001 for 8 cycles; pending returns to 0.
3. Preemption: req[1] playing, req[3] edge at play cycle 4 -> enable=1000 next cycle for a full 8 cycles. Source 1 never resumes and pending stays 0.
4. Same-cycle edges and retrigger: req edges 0101 in the same cycle -> idx 2 plays and pending=0001. Re-edge req[2] at play cycle 6 -> timer restarts, giving 14 total enabled cycles.
5. clear: clear pulse mid-PLAY with pending=0011 -> next cycle enable=0, pending=0, busy_play=0. An edge coinciding with clear is ignored.
6. Async reset: rst_n asserted mid-GAP with pending≠0 -> all outputs 0 immediately, without waiting for a clock edge. No playback after release until a fresh edge arrives.
